// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit.
//   SZ_B / SZ_H / SZ_W : access size encodings (2'b11 behaves as a word)
//   ST_*               : FSM state encodings
//   ctrl_t             : request control bits held for the duration of an op
//   lane_mask()        : byte lanes touched, bits [3:0] first word, [7:4] second word
//   needs_split()      : access crosses a word boundary
package lsu_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_ISSUE0 = 3'd1;
   localparam logic [2:0] ST_WAIT0  = 3'd2;
   localparam logic [2:0] ST_ISSUE1 = 3'd3;
   localparam logic [2:0] ST_WAIT1  = 3'd4;
   localparam logic [2:0] ST_RESP   = 3'd5;

   typedef struct packed {
      logic       we;
      logic [1:0] size;
      logic       zero_ext;
   } ctrl_t;

   function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [1:0] off);
      logic [7:0] base;
      case (size)
         SZ_B:    base = 8'h01;
         SZ_H:    base = 8'h03;
         default: base = 8'h0F;
      endcase
      return base << off;
   endfunction

   function automatic logic needs_split(input logic [1:0] size, input logic [1:0] off);
      logic split;
      case (size)
         SZ_B:    split = 1'b0;
         SZ_H:    split = (off == 2'd3);
         default: split = (off != 2'd0);
      endcase
      return split;
   endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane steering for the load/store unit.
//   size, zero_ext, offset : registered request attributes (offset = addr[1:0])
//   wdata                  : right-justified store data
//   lo_word, hi_word       : captured RAM words (first / second access)
//   mask                   : byte lanes, [3:0] first access, [7:4] second access
//   wdata_rot              : store data rotated left by 8*offset (same for both accesses)
//   rdata_ext              : load data shifted down and sign/zero extended
module lsu_lane_align
   import lsu_pkg::*;
(
   input  logic [1:0]  size,
   input  logic        zero_ext,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] lo_word,
   input  logic [31:0] hi_word,
   output logic [7:0]  mask,
   output logic [31:0] wdata_rot,
   output logic [31:0] rdata_ext
);

   logic [31:0] shifted;

   assign mask = lane_mask(size, offset);

   // A rotate lets the bytes that spill past lane 3 land in lanes 0.. of the second word.
   assign wdata_rot = 32'({wdata, wdata} >> (6'd32 - {1'b0, offset, 3'b000}));

   assign shifted = 32'({hi_word, lo_word} >> {offset, 3'b000});

   always_comb begin
      rdata_ext = shifted;
      case (size)
         SZ_B:    rdata_ext = zero_ext ? {24'h0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
         SZ_H:    rdata_ext = zero_ext ? {16'h0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
         default: rdata_ext = shifted;
      endcase
   end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the execute stage and a word-wide data RAM.
// Converts byte/half/word accesses into word-aligned RAM cycles with byte
// write enables; one request in flight, completion signalled by valid_o.
// Build option LSU_MISALIGN_SPLIT_EN: when defined, word-crossing accesses are
// split into two RAM accesses; otherwise they complete at once with misalign_o.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   req_i / ready_o    : request handshake
//   we_i, size_i, unsigned_i, addr_i, wdata_i : request attributes
//   valid_o, rdata_o, misalign_o              : completion
//   mem_addr_o, mem_wdata_o, mem_wen_o, mem_ren_o, mem_rdata_i : RAM side
//
// state  | meaning
// IDLE   | ready for a request
// ISSUE0 | first RAM access (word containing addr)
// WAIT0  | load: capture first RAM word
// ISSUE1 | second RAM access (next word), split builds only
// WAIT1  | load: capture second RAM word, split builds only
// RESP   | valid_o pulse
module load_store_unit
   import lsu_pkg::*;
#(
   parameter int ADDR_W = 32
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              req_i,
   input  logic              we_i,
   input  logic [1:0]        size_i,
   input  logic              unsigned_i,
   input  logic [ADDR_W-1:0] addr_i,
   input  logic [31:0]       wdata_i,
   output logic              ready_o,
   output logic              valid_o,
   output logic [31:0]       rdata_o,
   output logic              misalign_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   output logic [3:0]        mem_wen_o,
   output logic              mem_ren_o,
   input  logic [31:0]       mem_rdata_i
);

   logic [2:0]        state_q, state_d;
   ctrl_t             ctrl_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       lo_q;
   logic [31:0]       hi_word;
   logic [31:0]       rdata_q;
   logic              mis_q;
   logic [7:0]        lanes;
   logic [3:0]        wen0;
   logic [31:0]       wdata_rot;
   logic [31:0]       rdata_ext;
   logic [31:0]       resp_rdata;
   logic              resp_updates;
   logic [ADDR_W-1:0] word0;
   logic              accept;

   assign accept = req_i && (state_q == ST_IDLE);
   assign word0  = {addr_q[ADDR_W-1:2], 2'b00};

`ifdef LSU_MISALIGN_SPLIT_EN
   logic [31:0]       hi_q;
   logic [ADDR_W-1:0] word1;
   logic              split;

   assign hi_word = hi_q;
   assign word1   = word0 + ADDR_W'(4);
   assign split   = |lanes[7:4];
   assign mis_q   = 1'b0;
   assign wen0    = lanes[3:0];
`else
   assign hi_word = 32'h0;
   // A crossing op never reaches ISSUE0 here; the gate just keeps a partial
   // first-word write impossible should that ever change.
   assign wen0    = (|lanes[7:4]) ? 4'b0000 : lanes[3:0];
`endif

   lsu_lane_align u_align (
      .size      (ctrl_q.size),
      .zero_ext  (ctrl_q.zero_ext),
      .offset    (addr_q[1:0]),
      .wdata     (wdata_q),
      .lo_word   (lo_q),
      .hi_word   (hi_word),
      .mask      (lanes),
      .wdata_rot (wdata_rot),
      .rdata_ext (rdata_ext)
   );

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (req_i) begin
`ifdef LSU_MISALIGN_SPLIT_EN
               state_d = ST_ISSUE0;
`else
               state_d = needs_split(size_i, addr_i[1:0]) ? ST_RESP : ST_ISSUE0;
`endif
            end
         end
         ST_ISSUE0: begin
            if (!ctrl_q.we) begin
               state_d = ST_WAIT0;
            end else begin
`ifdef LSU_MISALIGN_SPLIT_EN
               state_d = split ? ST_ISSUE1 : ST_RESP;
`else
               state_d = ST_RESP;
`endif
            end
         end
         ST_WAIT0: begin
`ifdef LSU_MISALIGN_SPLIT_EN
            state_d = split ? ST_ISSUE1 : ST_RESP;
`else
            state_d = ST_RESP;
`endif
         end
`ifdef LSU_MISALIGN_SPLIT_EN
         ST_ISSUE1: state_d = ctrl_q.we ? ST_RESP : ST_WAIT1;
         ST_WAIT1:  state_d = ST_RESP;
`endif
         ST_RESP:   state_d = ST_IDLE;
         default:   state_d = ST_IDLE;
      endcase
   end

   // Loads and flagged ops refresh rdata_o; clean stores leave it untouched.
   assign resp_updates = !ctrl_q.we || mis_q;
   assign resp_rdata   = mis_q ? 32'h0 : rdata_ext;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         ctrl_q  <= '0;
         addr_q  <= '0;
         wdata_q <= '0;
         lo_q    <= '0;
         rdata_q <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
         hi_q    <= '0;
`else
         mis_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         if (accept) begin
            ctrl_q.we       <= we_i;
            ctrl_q.size     <= size_i;
            ctrl_q.zero_ext <= unsigned_i;
            addr_q          <= addr_i;
            wdata_q         <= wdata_i;
            lo_q            <= '0;
`ifdef LSU_MISALIGN_SPLIT_EN
            hi_q            <= '0;
`else
            mis_q           <= needs_split(size_i, addr_i[1:0]);
`endif
         end
         if (state_q == ST_WAIT0) begin
            lo_q <= mem_rdata_i;
         end
`ifdef LSU_MISALIGN_SPLIT_EN
         if (state_q == ST_WAIT1) begin
            hi_q <= mem_rdata_i;
         end
`endif
         if ((state_q == ST_RESP) && resp_updates) begin
            rdata_q <= resp_rdata;
         end
      end
   end

   always_comb begin
      mem_addr_o  = '0;
      mem_wdata_o = '0;
      mem_wen_o   = '0;
      mem_ren_o   = 1'b0;
      if (!rst_i) begin
         case (state_q)
            ST_ISSUE0: begin
               mem_addr_o = word0;
               mem_ren_o  = !ctrl_q.we;
               if (ctrl_q.we) begin
                  mem_wdata_o = wdata_rot;
                  mem_wen_o   = wen0;
               end
            end
`ifdef LSU_MISALIGN_SPLIT_EN
            ST_ISSUE1: begin
               mem_addr_o = word1;
               mem_ren_o  = !ctrl_q.we;
               if (ctrl_q.we) begin
                  mem_wdata_o = wdata_rot;
                  mem_wen_o   = lanes[7:4];
               end
            end
`endif
            default: ;
         endcase
      end
   end

   assign ready_o = (state_q == ST_IDLE);
   assign valid_o = (state_q == ST_RESP);
   assign rdata_o = (valid_o && resp_updates) ? resp_rdata : rdata_q;

`ifdef LSU_MISALIGN_SPLIT_EN
   assign misalign_o = 1'b0;
`else
   assign misalign_o = valid_o && mis_q;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

   logic        clk_i = 1'b0;
   logic        rst_i = 1'b1;
   logic        req_i = 1'b0;
   logic        we_i = 1'b0;
   logic [1:0]  size_i = 2'b00;
   logic        unsigned_i = 1'b0;
   logic [31:0] addr_i = '0;
   logic [31:0] wdata_i = '0;
   logic        ready_o, valid_o, misalign_o, mem_ren_o;
   logic [31:0] rdata_o, mem_addr_o, mem_wdata_o;
   logic [3:0]  mem_wen_o;
   logic [31:0] mem_rdata_i = '0;

`ifdef LSU_MISALIGN_SPLIT_EN
   localparam bit SPLIT_EN = 1'b1;
`else
   localparam bit SPLIT_EN = 1'b0;
`endif

   load_store_unit #(.ADDR_W(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .req_i(req_i), .we_i(we_i), .size_i(size_i),
      .unsigned_i(unsigned_i), .addr_i(addr_i), .wdata_i(wdata_i), .ready_o(ready_o),
      .valid_o(valid_o), .rdata_o(rdata_o), .misalign_o(misalign_o),
      .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_wen_o(mem_wen_o),
      .mem_ren_o(mem_ren_o), .mem_rdata_i(mem_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [31:0] rdata;
      logic        mis;
      int          lat;
   } exp_t;

   typedef struct {
      logic [31:0] addr;
      logic [3:0]  wen;
      logic [31:0] wdata;
      logic        ren;
   } acc_t;

   exp_t        exp_q[$];
   acc_t        acc_q[$];
   logic [31:0] ram[bit [31:0]];
   logic [7:0]  shadow[bit [31:0]];
   int          n_checks = 0;
   int          n_pass = 0;
   logic [31:0] model_rdata = '0;
   logic [31:0] obs_rdata;
   logic        obs_mis;
   int          obs_lat;
   bit          obs_to;
   logic        rd_pend = 1'b0;
   logic [31:0] rd_data = '0;
   logic [31:0] wword;

   // RAM model, sampled mid-cycle: writes land, reads return data in the following cycle.
   always @(negedge clk_i) begin
      mem_rdata_i <= rd_pend ? rd_data : 32'hBAD0_BAD0;
      rd_pend     <= mem_ren_o;
      if (mem_ren_o)
         rd_data <= ram.exists(mem_addr_o) ? ram[mem_addr_o] : 32'h0;
      if (mem_ren_o || (mem_wen_o != 4'b0000))
         acc_q.push_back('{mem_addr_o, mem_wen_o, mem_wdata_o, mem_ren_o});
      if (mem_wen_o != 4'b0000) begin
         wword = ram.exists(mem_addr_o) ? ram[mem_addr_o] : 32'h0;
         for (int i = 0; i < 4; i++)
            if (mem_wen_o[i]) wword[8*i +: 8] = mem_wdata_o[8*i +: 8];
         ram[mem_addr_o] = wword;
      end
   end

   function automatic int nbytes(input logic [1:0] size);
      return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
   endfunction

   // Issue one op, push its expectation, wait (bounded) for valid_o.
   task automatic do_op(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata);
      exp_t        ev;
      int          nb;
      bit          split;
      logic [31:0] a;
      logic [31:0] v;
      nb    = nbytes(size);
      split = (int'(addr[1:0]) + nb) > 4;
      ev.mis = 1'b0;
      if (split && !SPLIT_EN) begin
         ev.mis = 1'b1;
         ev.lat = 1;
         model_rdata = 32'h0;
      end else begin
         if (we) begin
            for (int i = 0; i < nb; i++) begin
               a = addr + 32'(i);
               shadow[a] = wdata[8*i +: 8];
            end
         end else begin
            v = 32'h0;
            for (int i = 0; i < nb; i++) begin
               a = addr + 32'(i);
               v[8*i +: 8] = shadow.exists(a) ? shadow[a] : 8'h00;
            end
            if (nb == 1 && !uns) v = {{24{v[7]}}, v[7:0]};
            if (nb == 2 && !uns) v = {{16{v[15]}}, v[15:0]};
            model_rdata = v;
         end
         ev.lat = we ? (split ? 3 : 2) : (split ? 5 : 3);
      end
      ev.rdata = model_rdata;
      exp_q.push_back(ev);
      @(negedge clk_i);
      req_i = 1'b1; we_i = we; size_i = size; unsigned_i = uns; addr_i = addr; wdata_i = wdata;
      @(posedge clk_i);
      obs_lat = 0;
      do begin
         @(negedge clk_i);
         req_i = 1'b0;
         obs_lat++;
      end while (!valid_o && obs_lat < 20);
      obs_to    = !valid_o;
      obs_rdata = rdata_o;
      obs_mis   = misalign_o;
   endtask

   task automatic test_reset();
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      n_checks++;
      if (mem_wen_o !== 4'b0 || mem_ren_o !== 1'b0 || mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0)
         $display("FAIL reset_mem: wen=%b ren=%b addr=%h wdata=%h want all 0", mem_wen_o, mem_ren_o, mem_addr_o, mem_wdata_o);
      else n_pass++;
      @(posedge clk_i); #1 rst_i = 1'b0;
      @(negedge clk_i);
      n_checks++;
      if (ready_o !== 1'b1) $display("FAIL reset_ready: got %b want 1", ready_o); else n_pass++;
      n_checks++;
      if (valid_o !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid_o); else n_pass++;
      n_checks++;
      if (rdata_o !== 32'h0) $display("FAIL reset_rdata: got %h want 0", rdata_o); else n_pass++;
      n_checks++;
      if (misalign_o !== 1'b0) $display("FAIL reset_misalign: got %b want 0", misalign_o); else n_pass++;
   endtask

   task automatic test_store_word();
      exp_t ev;
      acc_q.delete();
      do_op(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
      ev = exp_q.pop_front();
      n_checks++;
      if (obs_to || obs_rdata !== ev.rdata || obs_mis !== ev.mis || obs_lat != ev.lat)
         $display("FAIL sw_resp: got rdata=%h mis=%b lat=%0d to=%0b want rdata=%h mis=%b lat=%0d", obs_rdata, obs_mis, obs_lat, obs_to, ev.rdata, ev.mis, ev.lat);
      else n_pass++;
      n_checks++;
      if (acc_q.size() != 1 || acc_q[0].addr !== 32'h10 || acc_q[0].wen !== 4'b1111 || acc_q[0].wdata !== 32'hDEADBEEF)
         $display("FAIL sw_access: got n=%0d addr=%h wen=%b wdata=%h want n=1 addr=00000010 wen=1111 wdata=deadbeef", acc_q.size(), acc_q[0].addr, acc_q[0].wen, acc_q[0].wdata);
      else n_pass++;
      do_op(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
      ev = exp_q.pop_front();
      n_checks++;
      if (obs_to || obs_rdata !== ev.rdata || obs_mis !== ev.mis || obs_lat != ev.lat)
         $display("FAIL lw_resp: got rdata=%h mis=%b lat=%0d to=%0b want rdata=%h mis=%b lat=%0d", obs_rdata, obs_mis, obs_lat, obs_to, ev.rdata, ev.mis, ev.lat);
      else n_pass++;
   endtask

   task automatic test_byte();
      exp_t ev;
      acc_q.delete();
      do_op(1'b1, 2'b00, 1'b0, 32'h13, 32'h000000A5);
      ev = exp_q.pop_front();
      n_checks++;
      if (obs_to || obs_rdata !== ev.rdata || obs_lat != ev.lat)
         $display("FAIL sb_resp: got rdata=%h lat=%0d to=%0b want rdata=%h lat=%0d", obs_rdata, obs_lat, obs_to, ev.rdata, ev.lat);
      else n_pass++;
      n_checks++;
      if (acc_q.size() != 1 || acc_q[0].addr !== 32'h10 || acc_q[0].wen !== 4'b1000 || acc_q[0].wdata[31:24] !== 8'hA5)
         $display("FAIL sb_access: got n=%0d addr=%h wen=%b wdata=%h want addr=00000010 wen=1000 wdata[31:24]=a5", acc_q.size(), acc_q[0].addr, acc_q[0].wen, acc_q[0].wdata);
      else n_pass++;
      do_op(1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
      ev = exp_q.pop_front();
      n_checks++;
      if (obs_to || obs_rdata !== 32'hFFFFFFA5 || obs_rdata !== ev.rdata || obs_lat != ev.lat)
         $display("FAIL lb_resp: got rdata=%h lat=%0d to=%0b want rdata=ffffffa5 lat=%0d", obs_rdata, obs_lat, obs_to, ev.lat);
      else n_pass++;
   endtask

   task automatic test_ext();
      exp_t        ev;
      logic [1:0]  sz[5]  = '{2'b00, 2'b01, 2'b01, 2'b00, 2'b01};
      logic        un[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
      logic [31:0] ad[5]  = '{32'h21, 32'h22, 32'h22, 32'h20, 32'h20};
      logic [31:0] lit[5] = '{32'h00000082, 32'hFFFF8081, 32'h00008081, 32'hFFFFFF83, 32'h00008283};
      do_op(1'b1, 2'b10, 1'b0, 32'h20, 32'h80818283);
      ev = exp_q.pop_front();
      n_checks++;
      if (obs_to || obs_rdata !== ev.rdata || obs_lat != ev.lat)
         $display("FAIL ext_sw: got rdata=%h lat=%0d to=%0b want rdata=%h lat=%0d", obs_rdata, obs_lat, obs_to, ev.rdata, ev.lat);
      else n_pass++;
      for (int i = 0; i < 5; i++) begin
         do_op(1'b0, sz[i], un[i], ad[i], 32'h0);
         ev = exp_q.pop_front();
         n_checks++;
         if (obs_to || obs_rdata !== lit[i] || obs_rdata !== ev.rdata || obs_mis !== 1'b0 || obs_lat != ev.lat)
            $display("FAIL ext_load%0d: got rdata=%h mis=%b lat=%0d to=%0b want rdata=%h mis=0 lat=%0d", i, obs_rdata, obs_mis, obs_lat, obs_to, lit[i], ev.lat);
         else n_pass++;
      end
   endtask

   task automatic test_misalign();
      exp_t ev;
      acc_q.delete();
      do_op(1'b1, 2'b10, 1'b0, 32'h1E, 32'h11223344);
      ev = exp_q.pop_front();
      n_checks++;
      if (obs_to || obs_rdata !== ev.rdata || obs_mis !== ev.mis || obs_lat != ev.lat)
         $display("FAIL mis_sw: got rdata=%h mis=%b lat=%0d to=%0b want rdata=%h mis=%b lat=%0d", obs_rdata, obs_mis, obs_lat, obs_to, ev.rdata, ev.mis, ev.lat);
      else n_pass++;
`ifdef LSU_MISALIGN_SPLIT_EN
      n_checks++;
      if (acc_q.size() != 2 || acc_q[0].addr !== 32'h1C || acc_q[0].wen !== 4'b1100 || acc_q[1].addr !== 32'h20 || acc_q[1].wen !== 4'b0011)
         $display("FAIL mis_split_access: got n=%0d a0=%h w0=%b a1=%h w1=%b want 2 accesses 0000001c/1100 00000020/0011", acc_q.size(), acc_q[0].addr, acc_q[0].wen, acc_q[1].addr, acc_q[1].wen);
      else n_pass++;
`else
      n_checks++;
      if (acc_q.size() != 0 || obs_mis !== 1'b1 || obs_rdata !== 32'h0)
         $display("FAIL mis_flag: got accesses=%0d mis=%b rdata=%h want accesses=0 mis=1 rdata=0", acc_q.size(), obs_mis, obs_rdata);
      else n_pass++;
`endif
      do_op(1'b0, 2'b10, 1'b0, 32'h1E, 32'h0);
      ev = exp_q.pop_front();
      n_checks++;
      if (obs_to || obs_rdata !== ev.rdata || obs_mis !== ev.mis || obs_lat != ev.lat)
         $display("FAIL mis_lw: got rdata=%h mis=%b lat=%0d to=%0b want rdata=%h mis=%b lat=%0d", obs_rdata, obs_mis, obs_lat, obs_to, ev.rdata, ev.mis, ev.lat);
      else n_pass++;
   endtask

   task automatic test_wrap();
      exp_t ev;
      acc_q.delete();
      do_op(1'b1, 2'b10, 1'b0, 32'hFFFFFFFE, 32'hCAFEF00D);
      ev = exp_q.pop_front();
      n_checks++;
      if (obs_to || obs_mis !== ev.mis || obs_lat != ev.lat)
         $display("FAIL wrap_sw: got mis=%b lat=%0d to=%0b want mis=%b lat=%0d", obs_mis, obs_lat, obs_to, ev.mis, ev.lat);
      else n_pass++;
`ifdef LSU_MISALIGN_SPLIT_EN
      n_checks++;
      if (acc_q.size() != 2 || acc_q[0].addr !== 32'hFFFFFFFC || acc_q[1].addr !== 32'h0 || acc_q[1].wen !== 4'b0011)
         $display("FAIL wrap_access: got n=%0d a0=%h a1=%h w1=%b want fffffffc then 00000000/0011", acc_q.size(), acc_q[0].addr, acc_q[1].addr, acc_q[1].wen);
      else n_pass++;
`endif
      do_op(1'b0, 2'b10, 1'b0, 32'hFFFFFFFE, 32'h0);
      ev = exp_q.pop_front();
      n_checks++;
      if (obs_to || obs_rdata !== ev.rdata || obs_mis !== ev.mis || obs_lat != ev.lat)
         $display("FAIL wrap_lw: got rdata=%h mis=%b lat=%0d to=%0b want rdata=%h mis=%b lat=%0d", obs_rdata, obs_mis, obs_lat, obs_to, ev.rdata, ev.mis, ev.lat);
      else n_pass++;
   endtask

   // Reset in the cycle of a store's first access: no write may escape.
   task automatic test_reset_gate();
      exp_t ev;
      @(negedge clk_i);
      req_i = 1'b1; we_i = 1'b1; size_i = 2'b10; unsigned_i = 1'b0; addr_i = 32'h30; wdata_i = 32'h55AA55AA;
      @(posedge clk_i);
      #1 req_i = 1'b0; rst_i = 1'b1;
      #1;
      n_checks++;
      if (mem_wen_o !== 4'b0 || mem_addr_o !== 32'h0 || mem_wdata_o !== 32'h0)
         $display("FAIL rst_gate: got wen=%b addr=%h wdata=%h want 0", mem_wen_o, mem_addr_o, mem_wdata_o);
      else n_pass++;
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      model_rdata = 32'h0;
      do_op(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
      ev = exp_q.pop_front();
      n_checks++;
      if (obs_to || obs_rdata !== ev.rdata || obs_lat != ev.lat)
         $display("FAIL rst_gate_lw: got rdata=%h lat=%0d to=%0b want rdata=%h lat=%0d", obs_rdata, obs_lat, obs_to, ev.rdata, ev.lat);
      else n_pass++;
   endtask

   // Reset while the first word of a load is being captured.
   task automatic test_reset_mid();
      int n_valid;
      acc_q.delete();
      @(negedge clk_i);
      req_i = 1'b1; we_i = 1'b0; size_i = 2'b10; unsigned_i = 1'b0;
      addr_i = SPLIT_EN ? 32'h1E : 32'h24;
      @(posedge clk_i);
      @(negedge clk_i);
      req_i = 1'b0;
      @(posedge clk_i);
      #1 rst_i = 1'b1;
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      model_rdata = 32'h0;
      @(negedge clk_i);
      n_checks++;
      if (ready_o !== 1'b1 || valid_o !== 1'b0 || rdata_o !== 32'h0 || misalign_o !== 1'b0)
         $display("FAIL rst_mid_state: got ready=%b valid=%b rdata=%h mis=%b want 1 0 0 0", ready_o, valid_o, rdata_o, misalign_o);
      else n_pass++;
      n_valid = 0;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk_i);
         if (valid_o) n_valid++;
      end
      n_checks++;
      if (n_valid != 0 || acc_q.size() != 1)
         $display("FAIL rst_mid_quiet: got valid pulses=%0d accesses=%0d want 0 and 1", n_valid, acc_q.size());
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      exp_t        ev;
      logic        we;
      logic [1:0]  sz;
      logic [31:0] ad;
      for (int i = 0; i < 30; i++) begin
         we = (i < 8) ? 1'b1 : 1'($urandom_range(0, 1));
         sz = 2'($urandom_range(0, 3));
         ad = 32'h40 + 32'($urandom_range(0, 31));
         do_op(we, sz, 1'($urandom_range(0, 1)), ad, $urandom);
         ev = exp_q.pop_front();
         n_checks++;
         if (obs_to || obs_rdata !== ev.rdata || obs_mis !== ev.mis || obs_lat != ev.lat)
            $display("FAIL b2b_%0d we=%b sz=%0d addr=%h: got rdata=%h mis=%b lat=%0d to=%0b want rdata=%h mis=%b lat=%0d", i, we, sz, ad, obs_rdata, obs_mis, obs_lat, obs_to, ev.rdata, ev.mis, ev.lat);
         else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_store_word();
      test_byte();
      test_ext();
      test_misalign();
      test_wrap();
      test_reset_gate();
      test_reset_mid();
      test_back_to_back();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
      $fatal(1);
   end

endmodule
